// File: rtl/decode_mac_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_mac_pipe_if
//  Description : Sample/result bundle for the decode datapath MAC.
//                The master drives a tagged operand pair in and receives
//                results. The slave (the MAC) takes operands and drives results.
//  Signals     : in_valid, din0, din1, mode, acc_first, acc_last  (master -> slave)
//                out_valid, dout, ovf                            (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_mac_pipe_if #(
  parameter int DIN0_WIDTH = 40,
  parameter int DIN1_WIDTH = 20,
  parameter int DOUT_WIDTH = 32
);
  logic                  in_valid;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  mode;
  logic                  acc_first;
  logic                  acc_last;
  logic                  out_valid;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (
    output in_valid, din0, din1, mode, acc_first, acc_last,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, mode, acc_first, acc_last,
    output out_valid, dout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/decode_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : decode_mac_pipe
//  Description : Pipelined signed multiply-accumulate for the decode datapath.
//                Full-width product runs through NUM_STAGE registers, then an
//                output stage that optionally accumulates over a group and
//                applies round-half-up / arithmetic shift / saturation.
//                Latency NUM_STAGE+1 ce-cycles, one sample per ce-cycle.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous, active-low reset
//                ce     - clock enable; low freezes every register
//                bus    - decode_mac_pipe_if.slave (operands in, results out)
//  Assumes     : NUM_STAGE >= 1, ACC_WIDTH >= DIN0_WIDTH+DIN1_WIDTH,
//                ACC_WIDTH >= DOUT_WIDTH, 0 <= SHIFT < ACC_WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_mac_pipe #(
  parameter int DIN0_WIDTH = 40,
  parameter int DIN1_WIDTH = 20,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 64,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 0
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         ce,
  decode_mac_pipe_if.slave  bus
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LS = NUM_STAGE - 1;
  // One guard bit above the accumulator so the rounding add cannot wrap.
  localparam int EW = ACC_WIDTH + 1;

  // 2^(SHIFT-1) for SHIFT>0, zero for SHIFT=0, without a negative shift count.
  localparam logic signed [EW-1:0] C_RND = (EW'(1) << SHIFT) >> 1;
  localparam logic signed [EW-1:0] C_MAX = {{(EW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] C_MIN = {{(EW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Product pipeline: the product and its tags move together.
  // --------------------------------------------------------------------------
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_p [NUM_STAGE];
  logic [NUM_STAGE-1:0] r_vld;
  logic [NUM_STAGE-1:0] r_mode;
  logic [NUM_STAGE-1:0] r_first;
  logic [NUM_STAGE-1:0] r_last;

  assign w_prod = PW'($signed(bus.din0)) * PW'($signed(bus.din1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_p[i] <= '0;
      end
      r_vld   <= '0;
      r_mode  <= '0;
      r_first <= '0;
      r_last  <= '0;
    end else if (ce) begin
      r_p[0]     <= w_prod;
      r_vld[0]   <= bus.in_valid;
      r_mode[0]  <= bus.mode;
      r_first[0] <= bus.acc_first;
      r_last[0]  <= bus.acc_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_p[i]     <= r_p[i-1];
        r_vld[i]   <= r_vld[i-1];
        r_mode[i]  <= r_mode[i-1];
        r_first[i] <= r_first[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accumulate stage
  // --------------------------------------------------------------------------
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_gov;       // group accumulator has wrapped
  logic signed [ACC_WIDTH-1:0] w_p_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_add_ovf;
  logic signed [ACC_WIDTH-1:0] w_acc_nxt;
  logic                        w_gov_nxt;
  logic signed [ACC_WIDTH-1:0] w_v;
  logic                        w_emit;

  assign w_p_ext = ACC_WIDTH'(r_p[LS]);
  assign w_sum   = r_acc + w_p_ext;
  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign w_add_ovf = (r_acc[ACC_WIDTH-1] == w_p_ext[ACC_WIDTH-1]) &&
                     (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

  always_comb begin
    w_acc_nxt = r_acc;
    w_gov_nxt = r_gov;
    w_v       = w_p_ext;
    w_emit    = 1'b0;
    if (r_vld[LS]) begin
      if (!r_mode[LS]) begin
        w_emit = 1'b1;
      end else begin
        if (r_first[LS]) begin
          w_acc_nxt = w_p_ext;
          w_gov_nxt = 1'b0;
        end else begin
          w_acc_nxt = w_sum;
          w_gov_nxt = r_gov | w_add_ovf;
        end
        w_v    = w_acc_nxt;
        w_emit = r_last[LS];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round half toward +inf, arithmetic shift, saturate to DOUT_WIDTH.
  // --------------------------------------------------------------------------
  logic signed [EW-1:0]         w_vx;
  logic signed [EW-1:0]         w_rnd;
  logic signed [EW-1:0]         w_sh;
  logic        [DOUT_WIDTH-1:0] w_res;
  logic                         w_clip;
  logic                         w_ovf_out;

  assign w_vx  = EW'(w_v);
  assign w_rnd = w_vx + C_RND;
  assign w_sh  = w_rnd >>> SHIFT;

  always_comb begin
    w_res  = w_sh[DOUT_WIDTH-1:0];
    w_clip = 1'b0;
    if (w_sh > C_MAX) begin
      w_res  = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      w_clip = 1'b1;
    end else if (w_sh < C_MIN) begin
      w_res  = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      w_clip = 1'b1;
    end
  end

  // The group flag only qualifies results that close a group.
  assign w_ovf_out = w_clip | (r_mode[LS] & w_gov_nxt);

  // --------------------------------------------------------------------------
  // Output / accumulator registers
  // --------------------------------------------------------------------------
  logic                  r_out_valid;
  logic [DOUT_WIDTH-1:0] r_dout;
  logic                  r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_gov       <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_ovf       <= 1'b0;
    end else if (ce) begin
      r_acc       <= w_acc_nxt;
      r_gov       <= w_gov_nxt;
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_dout <= w_res;
        r_ovf  <= w_ovf_out;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
